// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter for the GPR write port: ALU results take priority over buffered
// LSU load results, and a load scoreboard flags registers that still await their load data.
module riscv_wb_arbiter #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned LSU_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            alu_valid_i,
   input  logic [4:0]      alu_rd_i,
   input  logic [XLEN-1:0] alu_wd_i,
   input  logic            lsu_valid_i,
   output logic            lsu_ready_o,
   input  logic [4:0]      lsu_rd_i,
   input  logic [XLEN-1:0] lsu_wd_i,
   input  logic            issue_load_i,
   input  logic [4:0]      issue_rd_i,
   input  logic [4:0]      ra1_i,
   input  logic [4:0]      ra2_i,
   output logic            busy1_o,
   output logic            busy2_o,
   output logic            gpr_we_o,
   output logic [4:0]      gpr_wa_o,
   output logic [XLEN-1:0] gpr_wd_o
);

   localparam int unsigned PTR_W = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(LSU_DEPTH + 1);
   localparam int unsigned NREG  = 32;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] wd;
   } lsu_entry_t;

   lsu_entry_t        fifo_mem [LSU_DEPTH];
   lsu_entry_t        head;
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              full, empty, push, pop;
   logic              src_lsu_q;
   logic [NREG-1:0]   sb_q, sb_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(LSU_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
   endfunction

   assign full        = (count_q == CNT_W'(LSU_DEPTH));
   assign empty       = (count_q == CNT_W'(0));
   assign lsu_ready_o = !full && !rst_i;
   assign push        = lsu_valid_i && lsu_ready_o;
   assign pop         = !alu_valid_i && !empty;
   assign head        = fifo_mem[rd_ptr_q];

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= PTR_W'(0);
         wr_ptr_q <= PTR_W'(0);
         count_q  <= CNT_W'(0);
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset; occupancy alone decides validity
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= '{rd: lsu_rd_i, wd: lsu_wd_i};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gpr_we_o  <= 1'b0;
         gpr_wa_o  <= 5'd0;
         gpr_wd_o  <= '0;
         src_lsu_q <= 1'b0;
      end else if (alu_valid_i) begin
         gpr_we_o  <= (alu_rd_i != 5'd0);
         gpr_wa_o  <= alu_rd_i;
         gpr_wd_o  <= alu_wd_i;
         src_lsu_q <= 1'b0;
      end else if (!empty) begin
         gpr_we_o  <= (head.rd != 5'd0);
         gpr_wa_o  <= head.rd;
         gpr_wd_o  <= head.wd;
         src_lsu_q <= 1'b1;
      end else begin
         gpr_we_o  <= 1'b0;
         src_lsu_q <= 1'b0;
      end
   end

   // Clear on LSU commit, then set on issue so a same-edge collision stays busy
   always_comb begin
      sb_d = sb_q;
      if (gpr_we_o && src_lsu_q) sb_d[gpr_wa_o] = 1'b0;
      if (issue_load_i && (issue_rd_i != 5'd0)) sb_d[issue_rd_i] = 1'b1;
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sb_q <= '0;
      else       sb_q <= sb_d;
   end

   assign busy1_o = sb_q[ra1_i];
   assign busy2_o = sb_q[ra2_i];

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_riscv_wb_arbiter;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned LSU_DEPTH = 2;

   logic            clk_i, rst_i;
   logic            alu_valid_i;
   logic [4:0]      alu_rd_i;
   logic [XLEN-1:0] alu_wd_i;
   logic            lsu_valid_i, lsu_ready_o;
   logic [4:0]      lsu_rd_i;
   logic [XLEN-1:0] lsu_wd_i;
   logic            issue_load_i;
   logic [4:0]      issue_rd_i, ra1_i, ra2_i;
   logic            busy1_o, busy2_o;
   logic            gpr_we_o;
   logic [4:0]      gpr_wa_o;
   logic [XLEN-1:0] gpr_wd_o;

   riscv_wb_arbiter #(.XLEN(XLEN), .LSU_DEPTH(LSU_DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_wd_i(alu_wd_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
      .lsu_rd_i(lsu_rd_i), .lsu_wd_i(lsu_wd_i),
      .issue_load_i(issue_load_i), .issue_rd_i(issue_rd_i),
      .ra1_i(ra1_i), .ra2_i(ra2_i), .busy1_o(busy1_o), .busy2_o(busy2_o),
      .gpr_we_o(gpr_we_o), .gpr_wa_o(gpr_wa_o), .gpr_wd_o(gpr_wd_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int passed = 0;
   int total  = 0;
   bit cmp_en = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else
         passed++;
   endtask

   // Reference model: pending loads as a queue, pending registers as a bit set
   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] wd;
   } ent_t;

   ent_t            m_q[$];
   ent_t            m_e;
   bit [31:0]       m_sb  = '0;
   bit              m_we  = 0;
   bit              m_src = 0;
   bit              m_acc = 0;
   bit              m_hs;
   logic [4:0]      m_wa  = '0;
   logic [XLEN-1:0] m_wd  = '0;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_q.delete();
         m_sb = '0; m_we = 0; m_src = 0; m_acc = 0; m_wa = '0; m_wd = '0;
      end else begin
         m_hs  = lsu_valid_i && (m_q.size() < LSU_DEPTH);
         m_acc = m_hs;
         if (m_we && m_src) m_sb[m_wa] = 1'b0;
         if (issue_load_i && issue_rd_i != 5'd0) begin
            assert (!m_sb[issue_rd_i]) else $error("FAIL reissue: load issued to busy x%0d", issue_rd_i);
            m_sb[issue_rd_i] = 1'b1;
         end
         if (alu_valid_i) begin
            m_we = (alu_rd_i != 0); m_wa = alu_rd_i; m_wd = alu_wd_i; m_src = 0;
         end else if (m_q.size() > 0) begin
            m_e  = m_q.pop_front();
            m_we = (m_e.rd != 0); m_wa = m_e.rd; m_wd = m_e.wd; m_src = 1;
         end else begin
            m_we = 0; m_src = 0;
         end
         if (m_hs) m_q.push_back('{rd: lsu_rd_i, wd: lsu_wd_i});
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk_i) begin
      if (cmp_en) begin
         chk("gpr_we", gpr_we_o, m_we);
         if (m_we) begin
            chk("gpr_wa", gpr_wa_o, m_wa);
            chk("gpr_wd", gpr_wd_o, m_wd);
         end
         chk("lsu_ready", lsu_ready_o, !rst_i && (m_q.size() < LSU_DEPTH));
         chk("busy1", busy1_o, m_sb[ra1_i]);
         chk("busy2", busy2_o, m_sb[ra2_i]);
      end
   end

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic idle();
      alu_valid_i = 0; lsu_valid_i = 0; issue_load_i = 0;
   endtask

   initial begin
      logic [4:0] cand;
      bit         ok;
      rst_i = 0; idle();
      alu_rd_i = 0; alu_wd_i = 0; lsu_rd_i = 0; lsu_wd_i = 0;
      issue_rd_i = 0; ra1_i = 0; ra2_i = 0;
      #1 rst_i = 1;
      tick(); tick();
      chk("rst_we", gpr_we_o, 0);
      chk("rst_wa", gpr_wa_o, 0);
      chk("rst_wd", gpr_wd_o, 0);
      chk("rst_ready", lsu_ready_o, 0);
      rst_i = 0; cmp_en = 1;
      tick();
      chk("ready_after_rst", lsu_ready_o, 1);

      // ALU path and x0 suppression
      alu_valid_i = 1; alu_rd_i = 5; alu_wd_i = 32'hDEADBEEF;
      tick(); idle();
      chk("alu_we", gpr_we_o, 1);
      chk("alu_wa", gpr_wa_o, 5);
      chk("alu_wd", gpr_wd_o, 32'hDEADBEEF);
      alu_valid_i = 1; alu_rd_i = 0; alu_wd_i = 32'h55;
      tick(); idle();
      chk("alu_x0_we", gpr_we_o, 0);
      tick();

      // Load scoreboard: issue in c1, handshake in c4, write in c6, clear from c7
      ra1_i = 7; issue_load_i = 1; issue_rd_i = 7;
      tick(); idle();
      chk("sb_busy_c2", busy1_o, 1);
      tick();
      chk("sb_busy_c3", busy1_o, 1);
      tick();
      chk("sb_busy_c4", busy1_o, 1);
      lsu_valid_i = 1; lsu_rd_i = 7; lsu_wd_i = 32'h1234;
      tick(); idle();
      chk("sb_busy_c5", busy1_o, 1);
      chk("sb_we_c5", gpr_we_o, 0);
      tick();
      chk("sb_busy_c6", busy1_o, 1);
      chk("sb_we_c6", gpr_we_o, 1);
      chk("sb_wa_c6", gpr_wa_o, 7);
      chk("sb_wd_c6", gpr_wd_o, 32'h1234);
      tick();
      chk("sb_busy_c7", busy1_o, 0);
      chk("sb_we_c7", gpr_we_o, 0);
      tick();

      // Contention: ALU keeps the port while the FIFO fills and stays full
      alu_valid_i = 1; alu_rd_i = 1; alu_wd_i = 32'hA1;
      lsu_valid_i = 1; lsu_rd_i = 3; lsu_wd_i = 32'h33;
      tick();
      alu_rd_i = 2; alu_wd_i = 32'hA2; lsu_rd_i = 4; lsu_wd_i = 32'h44;
      tick();
      lsu_valid_i = 0;
      chk("cont_ready_C", lsu_ready_o, 0);
      alu_rd_i = 10; alu_wd_i = 32'hA10;
      tick();
      chk("cont_ready_D", lsu_ready_o, 0);
      chk("cont_wa_D", gpr_wa_o, 10);
      alu_rd_i = 11; alu_wd_i = 32'hA11;
      tick();
      chk("cont_ready_E", lsu_ready_o, 0);
      alu_rd_i = 12; alu_wd_i = 32'hA12;
      tick(); idle();
      chk("cont_ready_F", lsu_ready_o, 0);
      chk("cont_wa_F", gpr_wa_o, 12);
      tick();
      chk("cont_wa_G", gpr_wa_o, 3);
      chk("cont_wd_G", gpr_wd_o, 32'h33);
      tick();
      chk("cont_wa_H", gpr_wa_o, 4);
      chk("cont_wd_H", gpr_wd_o, 32'h44);
      tick();

      // Set/clear collision on x9
      ra1_i = 9; issue_load_i = 1; issue_rd_i = 9;
      tick(); idle();
      lsu_valid_i = 1; lsu_rd_i = 9; lsu_wd_i = 32'h99;
      tick(); idle();
      tick();
      chk("coll_we", gpr_we_o, 1);
      chk("coll_wa", gpr_wa_o, 9);
      issue_load_i = 1; issue_rd_i = 9;
      tick(); idle();
      chk("coll_busy", busy1_o, 1);
      lsu_valid_i = 1; lsu_rd_i = 9; lsu_wd_i = 32'h98;
      tick(); idle();
      tick(); tick();
      chk("coll_cleared", busy1_o, 0);

      // Ten back-to-back loads through a two-entry FIFO
      for (int i = 0; i < 10; i++) begin
         chk("wrap_ready", lsu_ready_o, 1);
         lsu_valid_i = 1; lsu_rd_i = 5'(i + 1); lsu_wd_i = 32'h100 + 32'(i);
         tick();
         if (i >= 1) begin
            chk("wrap_wa", gpr_wa_o, 64'(i));
            chk("wrap_wd", gpr_wd_o, 64'(32'h100 + 32'(i - 1)));
         end
      end
      idle();
      tick();
      chk("wrap_last_wa", gpr_wa_o, 10);
      tick();
      chk("wrap_idle_we", gpr_we_o, 0);

      // Reset with two FIFO entries and three pending loads
      ra1_i = 11; ra2_i = 13;
      issue_load_i = 1; issue_rd_i = 11; tick();
      issue_rd_i = 12; tick();
      issue_rd_i = 13; tick();
      issue_load_i = 0;
      alu_valid_i = 1; alu_rd_i = 1; alu_wd_i = 32'hF00D;
      lsu_valid_i = 1; lsu_rd_i = 11; lsu_wd_i = 32'hB11; tick();
      lsu_rd_i = 12; lsu_wd_i = 32'hB12; tick();
      lsu_valid_i = 0; tick();
      chk("mid_ready_full", lsu_ready_o, 0);
      chk("mid_busy1", busy1_o, 1);
      chk("mid_busy2", busy2_o, 1);
      chk("mid_wa_pre", gpr_wa_o, 1);
      rst_i = 1; idle();
      #1;
      chk("mid_rst_we", gpr_we_o, 0);
      chk("mid_rst_wa", gpr_wa_o, 0);
      chk("mid_rst_wd", gpr_wd_o, 0);
      chk("mid_rst_busy1", busy1_o, 0);
      chk("mid_rst_busy2", busy2_o, 0);
      chk("mid_rst_ready", lsu_ready_o, 0);
      tick();
      rst_i = 0;
      tick();
      chk("mid_rel_ready", lsu_ready_o, 1);
      chk("mid_rel_we1", gpr_we_o, 0);
      tick();
      chk("mid_rel_we2", gpr_we_o, 0);
      tick();
      chk("mid_rel_we3", gpr_we_o, 0);

      // Randomized traffic, with the LSU holding data until accepted
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            rst_i = 1; idle();
            tick();
            rst_i = 0;
            continue;
         end
         alu_valid_i = ($urandom_range(0, 9) < 3);
         alu_rd_i    = 5'($urandom_range(0, 31));
         alu_wd_i    = $urandom;
         if (!(lsu_valid_i && !m_acc)) begin
            lsu_valid_i = $urandom_range(0, 1) == 1;
            lsu_rd_i    = 5'($urandom_range(0, 31));
            lsu_wd_i    = $urandom;
         end
         cand = 5'($urandom_range(1, 31));
         ok   = !m_sb[cand] || (m_we && m_src && m_wa == cand);
         issue_load_i = ok && ($urandom_range(0, 9) < 3);
         issue_rd_i   = cand;
         ra1_i = 5'($urandom_range(0, 31));
         ra2_i = 5'($urandom_range(0, 31));
         tick();
      end
      idle();
      tick(); tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
